// File: rtl/aes_spi_slave.sv
// SPI front end for an AES core: shifts in {dir, plaintext, key}, launches the
// core with a one-cycle start pulse, then shifts the 128-bit result back out MSB-first.
module aes_spi_slave #(
   parameter int K   = 128,
   parameter int INV = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sck,
   input  logic           sdi,
   input  logic           load,
   output logic           sdo,
   output logic           done,
   output logic [K-1:0]   key,
   output logic [127:0]   plaintext,
   output logic           dec,
   output logic           start,
   input  logic           core_done,
   input  logic [127:0]   cyphertext
);

   localparam int TOTAL = (INV == 2) ? K + 136 : K + 128;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT_IN, ST_WAIT, ST_SHIFT_OUT} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TOTAL-1:0]   sr_q, sr_d;
   logic [K-1:0]       key_q, key_d;
   logic [127:0]       pt_q, pt_d;
   logic [127:0]       out_q, out_d;
   logic               dec_q, dec_d;
   logic               start_q, start_d;
   logic               done_q, done_d;

   // Stage [1] is the synchronized level, stage [2] its previous value for edge detection.
   logic [2:0]         sck_sync_q;
   logic [2:0]         load_sync_q;
   logic [1:0]         sdi_sync_q;

   logic sck_rise, sck_fall, load_rise, load_fall, dec_frame;

   assign sck_rise  =  sck_sync_q[1]  & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1]  &  sck_sync_q[2];
   assign load_rise =  load_sync_q[1] & ~load_sync_q[2];
   assign load_fall = ~load_sync_q[1] &  load_sync_q[2];

   always_comb begin
      if (INV == 2) dec_frame = (sr_q[TOTAL-1 -: 8] == 8'hFF);
      else          dec_frame = (INV == 1);
   end

   // NOTE: every next-state signal gets its hold value first so no path leaves it
   // unassigned; otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      key_d   = key_q;
      pt_d    = pt_q;
      dec_d   = dec_q;
      out_d   = out_q;
      done_d  = done_q;
      start_d = 1'b0;

      // A new frame strobe outranks everything, including a same-cycle sck edge.
      if (load_rise) begin
         state_d = ST_SHIFT_IN;
         cnt_d   = '0;
         done_d  = 1'b0;
         out_d   = '0;
      end else begin
         case (state_q)
            ST_SHIFT_IN: begin
               if (load_fall) begin
                  if (cnt_q == TOTAL_C) begin
                     key_d   = sr_q[K-1:0];
                     pt_d    = sr_q[K+127:K];
                     dec_d   = dec_frame;
                     start_d = 1'b1;
                     state_d = ST_WAIT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (sck_rise) begin
                  sr_d = {sr_q[TOTAL-2:0], sdi_sync_q[1]};
                  if (cnt_q != TOTAL_C) cnt_d = cnt_q + CW'(1);
               end
            end
            ST_WAIT: begin
               if (core_done) begin
                  out_d   = cyphertext;
                  done_d  = 1'b1;
                  state_d = ST_SHIFT_OUT;
               end
            end
            ST_SHIFT_OUT: begin
               if (sck_fall) out_d = {out_q[126:0], 1'b0};
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         key_q       <= '0;
         pt_q        <= '0;
         dec_q       <= 1'b0;
         out_q       <= '0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         sck_sync_q  <= '0;
         load_sync_q <= '0;
         sdi_sync_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         key_q       <= key_d;
         pt_q        <= pt_d;
         dec_q       <= dec_d;
         out_q       <= out_d;
         start_q     <= start_d;
         done_q      <= done_d;
         sck_sync_q  <= {sck_sync_q[1:0], sck};
         load_sync_q <= {load_sync_q[1:0], load};
         sdi_sync_q  <= {sdi_sync_q[0], sdi};
      end
   end

   assign sdo       = out_q[127];
   assign done      = done_q;
   assign key       = key_q;
   assign plaintext = pt_q;
   assign dec       = dec_q;
   assign start     = start_q;

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed + randomized bench for aes_spi_slave (K=128, INV=2) with a
// bit-stream reference model of frame capture and readout.
module tb_aes_spi_slave;

   localparam int K     = 128;
   localparam int INV   = 2;
   localparam int TOTAL = K + 136;
   localparam int HALF  = 3;

   typedef bit bitq_t[$];

   logic           clk = 1'b0;
   logic           reset, sck, sdi, load, core_done;
   logic           sdo, done, dec, start;
   logic [K-1:0]   key;
   logic [127:0]   plaintext, cyphertext;

   int compared   = 0;
   int mismatched = 0;
   int start_cnt  = 0;
   int start_run  = 0;
   int start_max  = 0;

   aes_spi_slave #(.K(K), .INV(INV)) dut (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck),
      .sdi        (sdi),
      .load       (load),
      .sdo        (sdo),
      .done       (done),
      .key        (key),
      .plaintext  (plaintext),
      .dec        (dec),
      .start      (start),
      .core_done  (core_done),
      .cyphertext (cyphertext)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start === 1'b1) begin
         start_cnt++;
         start_run++;
         if (start_run > start_max) start_max = start_run;
      end else begin
         start_run = 0;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic bitq_t mk_frame(input logic [7:0] dir, input logic [127:0] pt,
                                      input logic [K-1:0] k);
      bitq_t q;
      logic [TOTAL-1:0] f;
      f = {dir, pt, k};
      for (int i = TOTAL - 1; i >= 0; i--) q.push_back(f[i]);
      return q;
   endfunction

   // Reference: the captured fields are the last TOTAL bits of the stream.
   task automatic model(input bitq_t q, output logic [K-1:0] ek,
                        output logic [127:0] ep, output logic ed);
      logic [TOTAL-1:0] v;
      int base;
      base = q.size() - TOTAL;
      for (int i = 0; i < TOTAL; i++) v[TOTAL-1-i] = q[base+i];
      ek = v[K-1:0];
      ep = v[K+127:K];
      ed = (v[TOTAL-1 -: 8] == 8'hFF);
   endtask

   task automatic load_up();
      load = 1'b1;
      clks(4);
   endtask

   task automatic shift_bit(input bit b);
      sdi = b;
      clks(HALF);
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
   endtask

   task automatic load_down();
      clks(HALF);
      load = 1'b0;
      clks(5);
   endtask

   task automatic shift_all(input bitq_t q);
      foreach (q[i]) shift_bit(q[i]);
   endtask

   task automatic expect_capture(input bitq_t q, input int s0, input string tag);
      logic [K-1:0] ek;
      logic [127:0] ep;
      logic         ed;
      int t;
      model(q, ek, ep, ed);
      t = 0;
      while (start_cnt == s0 && t < 100) begin
         clks(1);
         t++;
      end
      clks(3);
      check({tag, "_start_count"}, 128'(start_cnt - s0), 128'd1);
      check({tag, "_key"}, key, ek);
      check({tag, "_plaintext"}, plaintext, ep);
      check({tag, "_dec"}, {127'd0, dec}, {127'd0, ed});
   endtask

   task automatic respond(input logic [127:0] ct, input string tag);
      int t;
      clks(4);
      cyphertext = ct;
      core_done  = 1'b1;
      t = 0;
      while (done !== 1'b1 && t < 20) begin
         clks(1);
         t++;
      end
      core_done  = 1'b0;
      cyphertext = rnd128();
      check({tag, "_done"}, {127'd0, done}, 128'd1);
      check({tag, "_sdo_first"}, {127'd0, sdo}, {127'd0, ct[127]});
   endtask

   // Reads n bits: the first is already on sdo, each further one follows an sck fall.
   task automatic read_bits(input int n, output logic [127:0] r);
      r = '0;
      r[127] = sdo;
      for (int i = 1; i < n; i++) begin
         sck = 1'b1;
         clks(HALF);
         sck = 1'b0;
         clks(HALF + 1);
         r[127-i] = sdo;
      end
   endtask

   task automatic finish_readout(input logic [127:0] ct, input string tag);
      logic [127:0] r;
      read_bits(128, r);
      check({tag, "_readout"}, r, ct);
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
      clks(HALF + 1);
      check({tag, "_sdo_drained"}, {127'd0, sdo}, 128'd0);
      check({tag, "_done_hold"}, {127'd0, done}, 128'd1);
   endtask

   task automatic op_stream(input bitq_t q, input logic [127:0] ct, input string tag);
      int s0;
      s0 = start_cnt;
      load_up();
      shift_all(q);
      load_down();
      expect_capture(q, s0, tag);
      respond(ct, tag);
      finish_readout(ct, tag);
   endtask

   initial begin
      bitq_t        q;
      logic [127:0] r, ct, v_key, v_pt, v_ct;
      int           s0;

      reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
      core_done = 1'b0; cyphertext = '0;
      clks(3);
      check("rst_key", key, 128'd0);
      check("rst_pt", plaintext, 128'd0);
      check("rst_flags", {124'd0, dec, start, done, sdo}, 128'd0);
      reset = 1'b0;
      clks(3);

      // Short frame: 100 bits must not launch the core.
      s0 = start_cnt;
      load_up();
      for (int i = 0; i < 100; i++) shift_bit(1'($urandom));
      load_down();
      clks(10);
      check("short_start", 128'(start_cnt - s0), 128'd0);
      check("short_key", key, 128'd0);
      check("short_pt", plaintext, 128'd0);
      check("short_done", {127'd0, done}, 128'd0);

      // Known-answer encrypt and decrypt.
      v_key = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
      v_pt  = 128'h3243F6A8885A308D313198A2E0370734;
      v_ct  = 128'h3925841D02DC09FBDC118597196A0B32;
      op_stream(mk_frame(8'h00, v_pt, v_key), v_ct, "enc");
      check("enc_key_literal", key, v_key);
      op_stream(mk_frame(8'hFF, v_ct, v_key), v_pt, "dec");
      check("dec_flag_literal", {127'd0, dec}, 128'd1);

      // Overlong frame: 8 extra leading bits are pushed out.
      q = mk_frame(8'hFF, rnd128(), rnd128());
      for (int i = 0; i < 8; i++) q.push_front(1'($urandom));
      op_stream(q, rnd128(), "long");

      // Reset mid-frame.
      load_up();
      for (int i = 0; i < 50; i++) shift_bit(1'($urandom));
      reset = 1'b1; load = 1'b0; sck = 1'b0;
      clks(1);
      check("midrst_key", key, 128'd0);
      check("midrst_pt", plaintext, 128'd0);
      check("midrst_flags", {124'd0, dec, start, done, sdo}, 128'd0);
      clks(2);
      reset = 1'b0;
      s0 = start_cnt;
      clks(20);
      check("midrst_no_start", 128'(start_cnt - s0), 128'd0);
      op_stream(mk_frame(8'($urandom), rnd128(), rnd128()), rnd128(), "after_rst");

      // Abort during readout, then a new frame on the same load high.
      q  = mk_frame(8'h00, rnd128(), rnd128());
      ct = rnd128();
      s0 = start_cnt;
      load_up();
      shift_all(q);
      load_down();
      expect_capture(q, s0, "abort_a");
      respond(ct, "abort_a");
      read_bits(40, r);
      check("abort_partial", {88'd0, r[127:88]}, {88'd0, ct[127:88]});
      load = 1'b1;
      clks(3);
      check("abort_done_low", {127'd0, done}, 128'd0);
      clks(1);
      q  = mk_frame(8'hFF, rnd128(), rnd128());
      ct = rnd128();
      s0 = start_cnt;
      shift_all(q);
      load_down();
      expect_capture(q, s0, "abort_b");
      respond(ct, "abort_b");
      finish_readout(ct, "abort_b");

      // Randomized frames with mixed direction bytes.
      for (int n = 0; n < 3; n++) begin
         logic [7:0] d;
         d = (n == 1) ? 8'hFF : 8'($urandom);
         op_stream(mk_frame(d, rnd128(), rnd128()), rnd128(), "rand");
      end

      check("start_width", 128'(start_max), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aes_spi_slave.md
AES_SPI_SLAVE -- requirements
Module: aes_spi_slave

Interface
REQ-001 Parameter K, default 128, means key width in bits; legal values are 128, 192 and 256.
REQ-002 Parameter INV, default 2, selects the direction mode: 0 is encrypt-only, 1 is decrypt-only, 2 is runtime-selectable through a direction byte.
REQ-003 Derived constant TOTAL SHALL be K+128+8 when INV==2, and K+128 otherwise.
REQ-004 Reset is asynchronous and active-high. The block has one clock.
REQ-005 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- sck  in  1  SPI clock from host
- sdi  in  1  serial data from host, sampled on sck rising edge
- load  in  1  host frame strobe; high while the host shifts the frame in
- sdo  out  1  serial result to host
- done  out  1  result ready for readout
- key  out  K  captured key
- plaintext  out  128  captured data block
- dec  out  1  1 means decrypt
- start  out  1  one-cycle pulse to the AES core
- core_done  in  1  AES core finished (level)
- cyphertext  in  128  AES core result, valid while core_done==1

Function
REQ-006 sck, sdi and load SHALL each pass through a 2-flop synchronizer to clk. The block SHALL use edge detection on the synchronized sck only.
REQ-007 The host SHALL hold sck high and low for at least 3 clk periods each. The block does not need to handle faster sck.
REQ-008 Frame order is MSB-first: {dir[7:0] (INV==2 only), plaintext[127:0], key[K-1:0]}.
REQ-009 The state machine has four states: IDLE, SHIFT_IN, WAIT, SHIFT_OUT.
REQ-010 IDLE to SHIFT_IN: on synchronized load rising. On entry, the bit counter clears and done clears.
REQ-011 In SHIFT_IN, each sck rising edge SHALL shift sdi into a TOTAL-bit shift register and increment the counter. The counter saturates at TOTAL, and the register keeps the last TOTAL bits.
REQ-012 SHIFT_IN, load falling, counter==TOTAL: the block SHALL latch key, plaintext and dec, then pulse start high for exactly one clk cycle (the cycle after the falling edge is detected), then go to WAIT.
REQ-013 SHIFT_IN, load falling, counter<TOTAL: the block SHALL return to IDLE with no start pulse, and key, plaintext and dec SHALL be unchanged.
REQ-014 dec SHALL equal (dir==8'hFF) when INV==2, 0 when INV==0, and 1 when INV==1.
REQ-015 WAIT, core_done==1: on the next cycle the block SHALL latch cyphertext into the output register, set done=1, drive sdo=cyphertext[127], and go to SHIFT_OUT.
REQ-016 In SHIFT_OUT, each sck falling edge SHALL advance sdo to the next lower bit. After 128 falling edges sdo SHALL hold 0.
REQ-017 sck edges in WAIT or IDLE SHALL be ignored.
REQ-018 done SHALL stay 1 after readout until load rises or reset asserts.
REQ-019 Synchronized load rising in WAIT or SHIFT_OUT SHALL abort the current operation: done clears, the counter clears, the state goes to SHIFT_IN, and any late core_done is ignored.
REQ-020 When load rising and an sck edge are detected in the same cycle, the load edge SHALL take priority, and that sck edge is not counted.

Reset
REQ-021 While reset==1, all of the following SHALL be 0: state=IDLE, counter, shift register, key, plaintext, dec, start, done, sdo, output register, synchronizers.
REQ-022 Reset asserted mid-frame, mid-WAIT or mid-readout SHALL abandon the operation. No start pulse follows reset release until a complete new frame arrives.

Verification
REQ-023 Encrypt, INV=2, K=128:
- stimulus: frame dir=00, plaintext=3243F6A8885A308D313198A2E0370734, key=2B7E151628AED2A6ABF7158809CF4F3C; then core_done with cyphertext=3925841D02DC09FBDC118597196A0B32
- response: key and plaintext match the frame, dec=0, exactly one start pulse, done=1, sdo=0 before the first readout sck, 128 bits read back equal to 3925841D...0B32
REQ-024 Decrypt, INV=2:
- stimulus: dir=FF, plaintext=3925841D02DC09FBDC118597196A0B32, same key; core returns 3243F6A8885A308D313198A2E0370734
- response: dec=1, and the readout equals 3243F6A8...0734
REQ-025 Short frame:
- stimulus: 100 bits, then load falls
- response: no start pulse, state IDLE, key and plaintext still 0
REQ-026 Overlong frame:
- stimulus: TOTAL+8 bits
- response: captured fields equal the last TOTAL bits, and one start pulse
REQ-027 Reset mid-frame:
- stimulus: reset asserted after 50 bits, released, then a full frame sent
- response: all outputs 0 during reset, one start pulse after the frame, and a correct readout
REQ-028 Abort during readout:
- stimulus: load rises after 40 readout bits
- response: done falls within 3 clk cycles, and a new frame completes normally
